// File: rtl/at_pkg.sv
// Shared constants for the AT-command transmit path: command codes, ASCII
// line terminators, the per-command byte-length table and the FSM state type.
package at_pkg;

  localparam int CLKS_PER_BIT_DEF = 434;
  localparam int MAX_LEN_DEF      = 24;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  localparam logic [2:0] CMD_AT     = 3'd0;
  localparam logic [2:0] CMD_CWMODE = 3'd1;
  localparam logic [2:0] CMD_CIPMUX = 3'd2;
  localparam logic [2:0] CMD_SERVER = 3'd3;
  localparam logic [2:0] CMD_SEND   = 3'd4;
  localparam logic [2:0] CMD_DATA   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  // Total bytes on the line per command, CR LF included; 0 marks an invalid code.
  function automatic logic [4:0] cmd_len(input logic [2:0] cmd);
    case (cmd)
      CMD_AT:     cmd_len = 5'd4;
      CMD_CWMODE: cmd_len = 5'd13;
      CMD_CIPMUX: cmd_len = 5'd13;
      CMD_SERVER: cmd_len = 5'd21;
      CMD_SEND:   cmd_len = 5'd16;
      CMD_DATA:   cmd_len = 5'd1;
      default:    cmd_len = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/at_cmd_rom.sv
// Combinational command ROM: (cmd_sel, idx) -> byte to send and a flag marking
// the final byte. Preset strings get CR LF appended; CMD_DATA returns the payload.
module at_cmd_rom
  import at_pkg::*;
#(
  parameter int IDX_W = 5
) (
  input  logic [2:0]       cmd_sel,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       data_byte,
  output logic [7:0]       rom_byte,
  output logic             last
);

  localparam int STR_W = 8 * 19;

  localparam logic [15:0]  S_AT     = "AT";
  localparam logic [87:0]  S_CWMODE = "AT+CWMODE=2";
  localparam logic [87:0]  S_CIPMUX = "AT+CIPMUX=1";
  localparam logic [151:0] S_SERVER = "AT+CIPSERVER=1,8080";
  localparam logic [111:0] S_SEND   = "AT+CIPSEND=0,1";

  logic [STR_W-1:0] str;
  logic [4:0]       len;
  logic [4:0]       str_len;
  logic [4:0]       i5;
  logic [7:0]       bit_off;

  assign len     = cmd_len(cmd_sel);
  assign str_len = len - 5'd2;
  assign i5      = 5'(idx);
  // Strings are right-aligned, so character i sits (str_len-1-i) bytes up.
  assign bit_off = {str_len - 5'd1 - i5, 3'b000};

  always_comb begin
    str = '0;
    case (cmd_sel)
      CMD_AT:     str = STR_W'(S_AT);
      CMD_CWMODE: str = STR_W'(S_CWMODE);
      CMD_CIPMUX: str = STR_W'(S_CIPMUX);
      CMD_SERVER: str = STR_W'(S_SERVER);
      CMD_SEND:   str = STR_W'(S_SEND);
      default:    str = '0;
    endcase
  end

  always_comb begin
    rom_byte = 8'h00;
    last     = 1'b1;
    if (cmd_sel == CMD_DATA) begin
      rom_byte = data_byte;
      last     = 1'b1;
    end else if (cmd_sel < CMD_DATA) begin
      if (i5 < str_len) begin
        rom_byte = str[bit_off +: 8];
      end else if (i5 == str_len) begin
        rom_byte = CR;
      end else begin
        rom_byte = LF;
      end
      last = (i5 >= len - 5'd1);
    end
  end

endmodule

// File: rtl/at_cmd_tx.sv
// AT-command transmit engine: accepts a command code, walks the command ROM and
// serialises each byte as an 8N1 UART frame on tx, back to back.
//
// Handshake: a command is taken on any rising edge where cmd_valid && cmd_ready;
// cmd_ready is only high in IDLE with tx_en set and reset released, and requests
// seen while not ready are dropped, never queued. Completion is a one-cycle done
// pulse, with err set alongside it for aborted or invalid commands.
module at_cmd_tx
  import at_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int MAX_LEN      = MAX_LEN_DEF
) (
  input  logic       iCLK,
  input  logic       RST,
  input  logic       tx_en,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_sel,
  input  logic [7:0] data_byte,
  output logic       cmd_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       tx,
  output tx_state_e  dbg_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(MAX_LEN);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state;
  logic [2:0]       cmd_q;
  logic [7:0]       data_q;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic             abort_q;
  logic [7:0]       rom_byte;
  logic             rom_last;
  logic             bit_end;

  assign bit_end   = (baud_cnt == BIT_LAST);
  assign cmd_ready = (state == ST_IDLE) && tx_en && !RST;
  assign dbg_state = state;

  at_cmd_rom #(
    .IDX_W(IDX_W)
  ) u_rom (
    .cmd_sel  (cmd_q),
    .idx      (idx),
    .data_byte(data_q),
    .rom_byte (rom_byte),
    .last     (rom_last)
  );

  always_ff @(posedge iCLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      idx      <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      abort_q  <= 1'b0;
      cmd_q    <= '0;
      data_q   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      // A tx_en drop anywhere in a byte is remembered until that byte's stop bit ends.
      if (busy && !tx_en) abort_q <= 1'b1;

      case (state)
        ST_IDLE: begin
          tx      <= 1'b1;
          abort_q <= 1'b0;
          idx     <= '0;
          if (cmd_valid && cmd_ready) begin
            cmd_q  <= cmd_sel;
            data_q <= data_byte;
            state  <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (cmd_q > CMD_DATA) begin
            done  <= 1'b1;
            err   <= 1'b1;
            state <= ST_IDLE;
          end else begin
            tx       <= 1'b0;
            busy     <= 1'b1;
            baud_cnt <= '0;
            state    <= ST_START;
          end
        end

        ST_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            tx       <= rom_byte[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= rom_byte[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (rom_last || abort_q || !tx_en) begin
              done  <= 1'b1;
              err   <= abort_q || !tx_en;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              // Advance straight into the next start bit, no idle gap.
              idx   <= idx + 1'b1;
              tx    <= 1'b0;
              state <= ST_START;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
